// File: rtl/synch_fifo_param.sv
// synch_fifo_param: parametrised single-clock FIFO.
// Provides an occupancy count, a free-space count, threshold flags, a
// synchronous flush and sticky overflow/underflow flags.
// Optional build macro: SYNCH_FIFO_FWFT_EN selects first-word fall-through
// reads. When it is left undefined, reads use a 1-cycle registered output.
// Full and empty are decided from the entry count, never from pointer
// equality. This lets every pointer value be used for storage.
module synch_fifo_param #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] write_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] read_data,
    output logic              full,
    output logic              empty,
    output logic              full_nxt,
    output logic              empty_nxt,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   data_avail,
    output logic [ADDR_W:0]   room_avail,
    output logic              overflow,
    output logic              underflow
);

    // Count-width constants. The comparisons are done at the same width
    // as the counter itself.
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   AF_C    = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0]   AE_C    = (ADDR_W+1)'(AE_THRESH);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    // Storage array. It has no reset, so it maps onto RAM resources.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_reg,  wr_ptr_next;
    logic [ADDR_W-1:0] rd_ptr_reg,  rd_ptr_next;
    logic [ADDR_W:0]   count_reg,   count_next;
    logic [ADDR_W:0]   room_reg;
    logic              full_reg,    empty_reg;
    logic              afull_reg,   aempty_reg;
    logic              ovf_reg,     ovf_next;
    logic              unf_reg,     unf_next;
    logic [DATA_W-1:0] rd_data_reg;
    logic              wr_acc,      rd_acc;
    logic              afull_next,  aempty_next;

    // Acceptance, next pointers, next count and sticky error flags.
    // A flush overrides any read or write in the same cycle.
    always_comb begin
        wr_acc      = wr_en & ~full_reg;
        rd_acc      = rd_en & ~empty_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        ovf_next    = ovf_reg | (wr_en & full_reg);
        unf_next    = unf_reg | (rd_en & empty_reg);
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
            ovf_next    = 1'b0;
            unf_next    = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_next = count_reg + CNT_ONE;
                2'b01:   count_next = count_reg - CNT_ONE;
                default: count_next = count_reg;
            endcase
        end
    end

    // Flag look-ahead. These values are loaded into the flag registers
    // on the next edge.
    always_comb begin
        full_nxt    = (count_next == DEPTH_C);
        empty_nxt   = (count_next == '0);
        afull_next  = (count_next >= AF_C);
        aempty_next = (count_next <= AE_C);
    end

    // Pointer, count and flag state. The reset is asynchronous and
    // active-low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            room_reg   <= DEPTH_C;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
            afull_reg  <= 1'b0;
            aempty_reg <= 1'b1;
            ovf_reg    <= 1'b0;
            unf_reg    <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            room_reg   <= DEPTH_C - count_next;
            full_reg   <= full_nxt;
            empty_reg  <= empty_nxt;
            afull_reg  <= afull_next;
            aempty_reg <= aempty_next;
            ovf_reg    <= ovf_next;
            unf_reg    <= unf_next;
        end
    end

    // Memory write port. A write in a flush cycle is dropped.
    always_ff @(posedge clk) begin
        if (wr_acc && !flush) begin
            mem[wr_ptr_reg] <= write_data;
        end
    end

`ifdef SYNCH_FIFO_FWFT_EN
    // Next head word after this edge. If the slot being written now
    // becomes the head, the incoming data bypasses the array. This
    // happens when the FIFO is empty or is draining its last entry.
    logic [DATA_W-1:0] head_next;

    always_comb begin
        head_next = mem[rd_ptr_next];
        if (wr_acc && (wr_ptr_reg == rd_ptr_next)) begin
            head_next = write_data;
        end
    end

    // Output register that tracks the head entry. It holds its last
    // value while the FIFO is empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_reg <= '0;
        end else if (!empty_nxt) begin
            rd_data_reg <= head_next;
        end
    end
`else
    // Registered read port. It loads only on an accepted read and
    // otherwise holds its value, including during a flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_reg <= '0;
        end else if (rd_acc && !flush) begin
            rd_data_reg <= mem[rd_ptr_reg];
        end
    end
`endif

    assign read_data    = rd_data_reg;
    assign full         = full_reg;
    assign empty        = empty_reg;
    assign almost_full  = afull_reg;
    assign almost_empty = aempty_reg;
    assign data_avail   = count_reg;
    assign room_avail   = room_reg;
    assign overflow     = ovf_reg;
    assign underflow    = unf_reg;

endmodule

// File: tb/tb_synch_fifo_param.sv
// Directed testbench for synch_fifo_param with its default parameters
// (DATA_W=16, DEPTH=8, AF_THRESH=6, AE_THRESH=2). It covers both read modes.
// It follows the SYNCH_FIFO_FWFT_EN macro.
module tb_synch_fifo_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        wr_en;
    logic [15:0] write_data;
    logic        rd_en;
    logic [15:0] read_data;
    logic        full, empty, full_nxt, empty_nxt;
    logic        almost_full, almost_empty;
    logic [3:0]  data_avail, room_avail;
    logic        overflow, underflow;
    logic [15:0] exp16;

    int checks   = 0;
    int failures = 0;

    synch_fifo_param dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .wr_en        (wr_en),
        .write_data   (write_data),
        .rd_en        (rd_en),
        .read_data    (read_data),
        .full         (full),
        .empty        (empty),
        .full_nxt     (full_nxt),
        .empty_nxt    (empty_nxt),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .data_avail   (data_avail),
        .room_avail   (room_avail),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d);
        wr_en      = 1'b1;
        write_data = d;
        step();
        wr_en      = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic check_reset_vals(input string pfx);
        check_val({pfx, "_avail"},  32'(data_avail),   32'd0);
        check_val({pfx, "_room"},   32'(room_avail),   32'd8);
        check_val({pfx, "_empty"},  32'(empty),        32'd1);
        check_val({pfx, "_full"},   32'(full),         32'd0);
        check_val({pfx, "_aempty"}, 32'(almost_empty), 32'd1);
        check_val({pfx, "_afull"},  32'(almost_full),  32'd0);
        check_val({pfx, "_ovf"},    32'(overflow),     32'd0);
        check_val({pfx, "_unf"},    32'(underflow),    32'd0);
        check_val({pfx, "_rdata"},  32'(read_data),    32'd0);
    endtask

    // Watchdog so that the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        flush      = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        write_data = '0;
        exp16      = '0;
        step();
        step();
        check_reset_vals("rst");
        reset = 1'b1;
        step();

        // Single write then read of 0x00A5
        push(16'h00A5);
        check_val("t1_avail_w", 32'(data_avail), 32'd1);
        check_val("t1_empty_w", 32'(empty),      32'd0);
`ifdef SYNCH_FIFO_FWFT_EN
        check_val("t1_rdata", 32'(read_data), 32'h00A5);
`endif
        rd_en = 1'b1;
        #1;
        check_val("t1_empty_nxt", 32'(empty_nxt), 32'd1);
        step();
        rd_en = 1'b0;
        check_val("t1_avail_r", 32'(data_avail), 32'd0);
        check_val("t1_empty_r", 32'(empty),      32'd1);
`ifndef SYNCH_FIFO_FWFT_EN
        check_val("t1_rdata", 32'(read_data), 32'h00A5);
`endif

        // Fill with ~1..~8
        for (int i = 1; i <= 8; i++) begin
            wr_en      = 1'b1;
            exp16      = 16'(i);
            write_data = ~exp16;
            if (i == 7) begin
                #1;
                check_val("t2_full_nxt7", 32'(full_nxt), 32'd0);
            end
            if (i == 8) begin
                #1;
                check_val("t2_full_nxt8", 32'(full_nxt), 32'd1);
            end
            step();
            if (i == 5) check_val("t2_afull5", 32'(almost_full), 32'd0);
            if (i == 6) check_val("t2_afull6", 32'(almost_full), 32'd1);
        end
        wr_en = 1'b0;
        check_val("t2_full",   32'(full),       32'd1);
        check_val("t2_room",   32'(room_avail), 32'd0);
        check_val("t2_avail",  32'(data_avail), 32'd8);
        check_val("t2_aempty", 32'(almost_empty), 32'd0);
        push(16'h5555);
        check_val("t2_ovf",       32'(overflow),   32'd1);
        check_val("t2_avail_ovf", 32'(data_avail), 32'd8);

        // Read 20 times. Data comes back in order, then the FIFO is empty
        // and further reads underflow.
        for (int j = 1; j <= 20; j++) begin
            rd_en = 1'b1;
            exp16 = 16'(j);
            exp16 = ~exp16;
`ifdef SYNCH_FIFO_FWFT_EN
            if (j <= 8) check_val($sformatf("t2_rd%0d", j), 32'(read_data), 32'(exp16));
`endif
            step();
`ifndef SYNCH_FIFO_FWFT_EN
            if (j <= 8) check_val($sformatf("t2_rd%0d", j), 32'(read_data), 32'(exp16));
`endif
            if (j == 8) begin
                check_val("t2_empty8", 32'(empty),     32'd1);
                check_val("t2_unf8",   32'(underflow), 32'd0);
            end
            if (j == 9) check_val("t2_unf9", 32'(underflow), 32'd1);
        end
        rd_en = 1'b0;
        check_val("t2_rd_hold", 32'(read_data),  32'hFFF7);
        check_val("t2_avail_0", 32'(data_avail), 32'd0);

        // Simultaneous read and write at count 4 for 16 cycles
        do_flush();
        check_val("t3_ovf_clr", 32'(overflow),  32'd0);
        check_val("t3_unf_clr", 32'(underflow), 32'd0);
        for (int i = 0; i < 4; i++) push(16'(32'h100 + i));
        for (int k = 0; k < 16; k++) begin
            wr_en      = 1'b1;
            rd_en      = 1'b1;
            write_data = 16'(32'h104 + k);
            exp16      = 16'(32'h100 + k);
`ifdef SYNCH_FIFO_FWFT_EN
            check_val($sformatf("t3_rd%0d", k), 32'(read_data), 32'(exp16));
`endif
            step();
`ifndef SYNCH_FIFO_FWFT_EN
            check_val($sformatf("t3_rd%0d", k), 32'(read_data), 32'(exp16));
`endif
            check_val($sformatf("t3_avail%0d", k), 32'(data_avail), 32'd4);
            check_val($sformatf("t3_flags%0d", k),
                      32'({full, empty, almost_full, almost_empty}), 32'd0);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;

        // Read and write together while empty: the write is accepted and
        // the read is rejected.
        do_flush();
        wr_en      = 1'b1;
        rd_en      = 1'b1;
        write_data = 16'h0BEE;
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_val("t4e_avail", 32'(data_avail), 32'd1);
        check_val("t4e_unf",   32'(underflow),  32'd1);
        check_val("t4e_ovf",   32'(overflow),   32'd0);
`ifdef SYNCH_FIFO_FWFT_EN
        check_val("t4e_rdata", 32'(read_data), 32'h0BEE);
`else
        check_val("t4e_rdata", 32'(read_data), 32'h010F);
`endif

        // Read and write together while full: the read is accepted and
        // the write is rejected.
        do_flush();
        for (int i = 0; i < 8; i++) push(16'(32'h200 + i));
        check_val("t4f_full", 32'(full), 32'd1);
        wr_en      = 1'b1;
        rd_en      = 1'b1;
        write_data = 16'h3333;
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_val("t4f_avail", 32'(data_avail), 32'd7);
        check_val("t4f_ovf",   32'(overflow),   32'd1);
        check_val("t4f_unf",   32'(underflow),  32'd0);
        check_val("t4f_full0", 32'(full),       32'd0);
`ifdef SYNCH_FIFO_FWFT_EN
        check_val("t4f_rdata", 32'(read_data), 32'h0201);
`else
        check_val("t4f_rdata", 32'(read_data), 32'h0200);
`endif

        // Flush at count 5 with a write in the same cycle
        do_flush();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check_val("t5_unf_set", 32'(underflow), 32'd1);
        for (int i = 0; i < 5; i++) push(16'(32'h400 + i));
        check_val("t5_avail5", 32'(data_avail), 32'd5);
        flush      = 1'b1;
        wr_en      = 1'b1;
        write_data = 16'h9999;
        step();
        flush = 1'b0;
        wr_en = 1'b0;
        check_val("t5_avail",  32'(data_avail),   32'd0);
        check_val("t5_empty",  32'(empty),        32'd1);
        check_val("t5_aempty", 32'(almost_empty), 32'd1);
        check_val("t5_room",   32'(room_avail),   32'd8);
        check_val("t5_ovf",    32'(overflow),     32'd0);
        check_val("t5_unf",    32'(underflow),    32'd0);
`ifdef SYNCH_FIFO_FWFT_EN
        check_val("t5_rdata_hold", 32'(read_data), 32'h0400);
`else
        check_val("t5_rdata_hold", 32'(read_data), 32'h0200);
`endif
        push(16'h1234);
        check_val("t5_avail1", 32'(data_avail), 32'd1);
`ifdef SYNCH_FIFO_FWFT_EN
        check_val("t5_rd1234", 32'(read_data), 32'h1234);
`endif
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
`ifndef SYNCH_FIFO_FWFT_EN
        check_val("t5_rd1234", 32'(read_data), 32'h1234);
`endif
        check_val("t5_avail_end", 32'(data_avail), 32'd0);

        // Asynchronous reset in the middle of a fill, at count 3
        for (int i = 0; i < 3; i++) push(16'(32'h700 + i));
        check_val("t6_avail3", 32'(data_avail), 32'd3);
        #3;
        reset = 1'b0;
        #1;
        check_reset_vals("t6_arst");
        #2;
        reset = 1'b1;
        step();
        push(16'h0777);
        check_val("t6_avail1", 32'(data_avail), 32'd1);
`ifdef SYNCH_FIFO_FWFT_EN
        check_val("t6_rdata", 32'(read_data), 32'h0777);
`endif
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
`ifndef SYNCH_FIFO_FWFT_EN
        check_val("t6_rdata", 32'(read_data), 32'h0777);
`endif
        check_val("t6_avail0", 32'(data_avail), 32'd0);
        check_val("t6_empty",  32'(empty),      32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
